// File: rtl/iter_muldiv_unit_if.sv
// Issue/result bundle between EX-stage control and the iterative multiply/divide unit.
interface iter_muldiv_unit_if #(
  parameter int WIDTH = 16,
  parameter int RD_W  = 4
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [RD_W-1:0]  rd_in;
  logic             flush;
  logic [1:0]       alu_status;
  logic [WIDTH-1:0] result;
  logic [RD_W-1:0]  result_rd;

  modport master (
    output start, op, a, b, rd_in, flush,
    input  alu_status, result, result_rd
  );

  modport slave (
    input  start, op, a, b, rd_in, flush,
    output alu_status, result, result_rd
  );
endinterface

// File: rtl/iter_muldiv_unit.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per cycle,
// with a one-cycle DONE window carrying the result and destination tag.
module iter_muldiv_unit #(
  parameter int WIDTH = 16,
  parameter int RD_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  iter_muldiv_unit_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  // state  | meaning
  // S_IDLE | no operation, waiting for start
  // S_RUN  | iterating, one bit per cycle
  // S_DONE | result and tag valid for this cycle only
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [RD_W-1:0]    rd_q;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     rem;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   result;
  logic [RD_W-1:0]    result_rd;

  logic [WIDTH:0]     prod_sum;
  logic [2*WIDTH-1:0] prod_nxt;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH+1:0]   rem_diff;
  logic [WIDTH:0]     rem_nxt;
  logic [WIDTH-1:0]   quo_nxt;
  logic [WIDTH-1:0]   res_nxt;
  logic [1:0]         status;

  // Both datapaths step every RUN cycle; op_q only selects which one is reported.
  always_comb begin
    prod_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, a_q & {WIDTH{prod[0]}}};
    prod_nxt  = {prod_sum, prod[WIDTH-1:1]};
    rem_shift = {rem[WIDTH-1:0], quo[WIDTH-1]};
    rem_diff  = {1'b0, rem_shift} - {2'b00, b_q};
    rem_nxt   = rem_diff[WIDTH+1] ? rem_shift : rem_diff[WIDTH:0];
    quo_nxt   = {quo[WIDTH-2:0], ~rem_diff[WIDTH+1]};
    case (op_q)
      2'b00:   res_nxt = prod_nxt[WIDTH-1:0];
      2'b01:   res_nxt = prod_nxt[2*WIDTH-1:WIDTH];
      2'b10:   res_nxt = quo_nxt;
      default: res_nxt = rem_nxt[WIDTH-1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rd_q      <= '0;
      prod      <= '0;
      rem       <= '0;
      quo       <= '0;
      result    <= '0;
      result_rd <= '0;
    end else if (bus.flush) begin
      state     <= S_IDLE;
      cnt       <= '0;
      result    <= '0;
      result_rd <= '0;
    end else begin
      case (state)
        S_RUN: begin
          prod <= prod_nxt;
          rem  <= rem_nxt;
          quo  <= quo_nxt;
          cnt  <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state     <= S_DONE;
            result    <= res_nxt;
            result_rd <= rd_q;
          end
        end
        default: begin
          // IDLE and DONE both accept a new issue; DONE->RUN gives back-to-back.
          result    <= '0;
          result_rd <= '0;
          if (bus.start) begin
            state <= S_RUN;
            cnt   <= CNT_W'(WIDTH);
            op_q  <= bus.op;
            a_q   <= bus.a;
            b_q   <= bus.b;
            rd_q  <= bus.rd_in;
            prod  <= {{WIDTH{1'b0}}, bus.b};
            rem   <= '0;
            quo   <= bus.a;
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

  always_comb begin
    status = 2'b00;
    case (state)
      S_RUN:   status = {1'b1, op_q[1]};
      S_DONE:  status = 2'b01;
      default: status = 2'b00;
    endcase
  end

  assign bus.alu_status = status;
  assign bus.result     = result;
  assign bus.result_rd  = result_rd;
endmodule

// File: tb/tb_iter_muldiv_unit.sv
// Scoreboard bench for iter_muldiv_unit: expected results queued at issue, checked at DONE.
module tb_iter_muldiv_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;

  iter_muldiv_unit_if #(.WIDTH(16), .RD_W(4)) bus ();

  iter_muldiv_unit #(.WIDTH(16), .RD_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    logic [3:0]  rd;
  } exp_t;

  typedef struct packed {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  rd;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic logic [15:0] model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    p = {16'h0, a} * {16'h0, b};
    case (op)
      2'b00:   return p[15:0];
      2'b01:   return p[31:16];
      2'b10:   return (b == 16'h0) ? 16'hFFFF : a / b;
      default: return (b == 16'h0) ? a : a % b;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge after the sampling edge with start low.
  task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] rd, input bit track);
    exp_t e;
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b; bus.rd_in = rd;
    if (track) begin
      e.res = model(op, a, b);
      e.rd  = rd;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = 16'($urandom);
    bus.b     = 16'($urandom);
    bus.op    = 2'($urandom);
    bus.rd_in = 4'($urandom);
  endtask

  // Counts busy negedges (including the current one) until DONE, bounded.
  task automatic wait_done(input logic [1:0] busy_code, output int cnt, output bit ok);
    cnt = 0;
    ok  = 1'b1;
    while (bus.alu_status !== 2'b01 && cnt < 40) begin
      if (bus.alu_status !== busy_code) ok = 1'b0;
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b1; bus.op = 2'b00; bus.a = 16'd5; bus.b = 16'd5; bus.rd_in = 4'd7;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.alu_status !== 2'b00) $display("FAIL reset_status: got %b expected 00", bus.alu_status); else n_pass++;
    n_checks++; if (bus.result !== 16'h0) $display("FAIL reset_result: got %h expected 0000", bus.result); else n_pass++;
    n_checks++; if (bus.result_rd !== 4'h0) $display("FAIL reset_rd: got %h expected 0", bus.result_rd); else n_pass++;
    rst = 1'b0; bus.start = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.alu_status !== 2'b00) $display("FAIL post_reset_idle: got %b expected 00", bus.alu_status); else n_pass++;
  endtask

  task automatic test_table(input string name, input logic [1:0] busy_code, input vec_t tv[]);
    int cnt; bit ok; exp_t e;
    foreach (tv[i]) begin
      issue(tv[i].op, tv[i].a, tv[i].b, tv[i].rd, 1'b1);
      wait_done(busy_code, cnt, ok);
      n_checks++; if (cnt !== 16) $display("FAIL %s_latency[%0d]: got %0d expected 16", name, i, cnt); else n_pass++;
      n_checks++; if (ok !== 1'b1) $display("FAIL %s_busy_code[%0d]: got mismatching status expected %b", name, i, busy_code); else n_pass++;
      n_checks++; if (bus.alu_status !== 2'b01) $display("FAIL %s_done[%0d]: got %b expected 01", name, i, bus.alu_status); else n_pass++;
      e = sb.pop_front();
      n_checks++; if (bus.result !== e.res) $display("FAIL %s_result[%0d]: got %h expected %h", name, i, bus.result, e.res); else n_pass++;
      n_checks++; if (bus.result_rd !== e.rd) $display("FAIL %s_rd[%0d]: got %h expected %h", name, i, bus.result_rd, e.rd); else n_pass++;
      @(negedge clk);
      n_checks++; if (bus.alu_status !== 2'b00) $display("FAIL %s_after_status[%0d]: got %b expected 00", name, i, bus.alu_status); else n_pass++;
      n_checks++; if (bus.result_rd !== 4'h0 || bus.result !== 16'h0)
        $display("FAIL %s_after_zero[%0d]: got %h/%h expected 0/0000", name, i, bus.result_rd, bus.result); else n_pass++;
    end
  endtask

  task automatic test_mul();
    vec_t tv[];
    tv = new[3];
    tv[0] = '{op: 2'd0, a: 16'd7,    b: 16'd6,    rd: 4'd3};
    tv[1] = '{op: 2'd1, a: 16'hFFFF, b: 16'hFFFF, rd: 4'd5};
    tv[2] = '{op: 2'd0, a: 16'hFFFF, b: 16'hFFFF, rd: 4'd6};
    test_table("mul", 2'b10, tv);
  endtask

  task automatic test_div_zero();
    vec_t tv[];
    tv = new[3];
    tv[0] = '{op: 2'd2, a: 16'h1234, b: 16'h0000, rd: 4'd1};
    tv[1] = '{op: 2'd3, a: 16'h1234, b: 16'h0000, rd: 4'd2};
    tv[2] = '{op: 2'd2, a: 16'hFFFF, b: 16'h0001, rd: 4'd4};
    test_table("divz", 2'b11, tv);
  endtask

  task automatic test_back_to_back();
    int cnt; bit ok; exp_t e;
    issue(2'b10, 16'd100, 16'd7, 4'd7, 1'b1);
    wait_done(2'b11, cnt, ok);
    n_checks++; if (cnt !== 16 || ok !== 1'b1) $display("FAIL b2b_div_busy: got %0d cycles ok=%0d expected 16 ok=1", cnt, ok); else n_pass++;
    e = sb.pop_front();
    n_checks++; if (bus.alu_status !== 2'b01 || bus.result !== e.res)
      $display("FAIL b2b_div_result: got %b/%h expected 01/%h", bus.alu_status, bus.result, e.res); else n_pass++;
    issue(2'b11, 16'd100, 16'd7, 4'd8, 1'b1);
    n_checks++; if (bus.alu_status !== 2'b11) $display("FAIL b2b_no_idle: got %b expected 11", bus.alu_status); else n_pass++;
    wait_done(2'b11, cnt, ok);
    n_checks++; if (cnt !== 16 || ok !== 1'b1) $display("FAIL b2b_rem_busy: got %0d cycles ok=%0d expected 16 ok=1", cnt, ok); else n_pass++;
    e = sb.pop_front();
    n_checks++; if (bus.result !== e.res || bus.result_rd !== e.rd)
      $display("FAIL b2b_rem_result: got %h/%h expected %h/%h", bus.result, bus.result_rd, e.res, e.rd); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_start_ignored();
    int cnt; bit ok; exp_t e;
    issue(2'b00, 16'd7, 16'd6, 4'd3, 1'b1);
    repeat (5) @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b10; bus.a = 16'd9; bus.b = 16'd2; bus.rd_in = 4'd9;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(2'b10, cnt, ok);
    n_checks++; if (cnt !== 10 || ok !== 1'b1) $display("FAIL ignore_busy: got %0d cycles ok=%0d expected 10 ok=1", cnt, ok); else n_pass++;
    e = sb.pop_front();
    n_checks++; if (bus.alu_status !== 2'b01 || bus.result !== e.res || bus.result_rd !== e.rd)
      $display("FAIL ignore_result: got %b/%h/%h expected 01/%h/%h", bus.alu_status, bus.result, bus.result_rd, e.res, e.rd); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_abort();
    int cnt; bit ok; bit seen; exp_t e;
    issue(2'b00, 16'd7, 16'd6, 4'd3, 1'b0);
    repeat (4) @(negedge clk);
    bus.flush = 1'b1; bus.start = 1'b1; bus.op = 2'b00; bus.rd_in = 4'd9;
    @(negedge clk);
    bus.flush = 1'b0; bus.start = 1'b0;
    n_checks++; if (bus.alu_status !== 2'b00 || bus.result_rd !== 4'h0)
      $display("FAIL flush_idle: got %b/%h expected 00/0", bus.alu_status, bus.result_rd); else n_pass++;
    seen = 1'b0;
    repeat (20) begin
      if (bus.alu_status !== 2'b00 || bus.result_rd !== 4'h0) seen = 1'b1;
      @(negedge clk);
    end
    n_checks++; if (seen !== 1'b0) $display("FAIL flush_no_done: got activity=1 expected 0"); else n_pass++;

    issue(2'b10, 16'h1234, 16'd3, 4'd5, 1'b0);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (bus.alu_status !== 2'b00 || bus.result_rd !== 4'h0)
      $display("FAIL rst_idle: got %b/%h expected 00/0", bus.alu_status, bus.result_rd); else n_pass++;
    seen = 1'b0;
    repeat (20) begin
      if (bus.alu_status !== 2'b00 || bus.result_rd !== 4'h0) seen = 1'b1;
      @(negedge clk);
    end
    n_checks++; if (seen !== 1'b0) $display("FAIL rst_no_done: got activity=1 expected 0"); else n_pass++;

    issue(2'b00, 16'd3, 16'd5, 4'd2, 1'b1);
    wait_done(2'b10, cnt, ok);
    n_checks++; if (cnt !== 16 || ok !== 1'b1) $display("FAIL fresh_busy: got %0d cycles ok=%0d expected 16 ok=1", cnt, ok); else n_pass++;
    e = sb.pop_front();
    n_checks++; if (bus.result !== 16'h000F || bus.result !== e.res || bus.result_rd !== e.rd)
      $display("FAIL fresh_result: got %h/%h expected 000f/%h", bus.result, bus.result_rd, e.rd); else n_pass++;
    @(negedge clk);
  endtask

  initial begin
    bus.start = 1'b0; bus.flush = 1'b0; bus.op = 2'b00;
    bus.a = 16'h0; bus.b = 16'h0; bus.rd_in = 4'h0;
    @(negedge clk);
    test_reset();
    test_mul();
    test_back_to_back();
    test_div_zero();
    test_start_ignored();
    test_abort();
    n_checks++; if (sb.size() !== 0) $display("FAIL scoreboard_empty: got %0d entries expected 0", sb.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
